// File: rtl/sum_serial_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sum_serial_pkg
// Purpose  : Shared FSM encoding and default width for the bit-serial adder.
// Revision : 1.0 - initial release
// ============================================================================
package sum_serial_pkg;

  localparam int c_default_width = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sum1bcc.sv
`default_nettype none
// ============================================================================
// Module   : sum1bcc
// Purpose  : Combinational 1-bit full-adder cell shared by the serial adder.
// Revision : 1.0 - initial release
// ============================================================================
module sum1bcc (
  input  logic x,
  input  logic y,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = x ^ y ^ c;
  assign carry = (x & y) | (x & c) | (y & c);

endmodule
`default_nettype wire

// File: rtl/sum_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sum_serial_ctrl
// Purpose  : Bit-serial WIDTH-bit adder, LSB first, one bit per clock.
// Revision : 1.0 - initial release
// ============================================================================
module sum_serial_ctrl
  import sum_serial_pkg::*;
#(
  parameter int WIDTH = c_default_width
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int              c_cw   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_cw-1:0] c_last = c_cw'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic [c_cw-1:0]  r_cnt;
  logic             w_sum;
  logic             w_carry;

  sum1bcc u_cell (
    .x     (r_op_a[0]),
    .y     (r_op_b[0]),
    .c     (r_carry),
    .sum   (w_sum),
    .carry (w_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          // Result bits enter at the MSB so bit 0 lands in place after WIDTH shifts.
          r_acc   <= {w_sum, r_acc[WIDTH-1:1]};
          r_carry <= w_carry;
          r_op_a  <= r_op_a >> 1;
          r_op_b  <= r_op_b >> 1;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == c_last) begin
            r_state <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            sum     <= {w_sum, r_acc[WIDTH-1:1]};
            cout    <= w_carry;
            ovf     <= r_carry ^ w_carry;
          end
        end
        default: begin
          done <= 1'b0;
          if (start) begin
            r_op_a  <= a;
            r_op_b  <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            r_state <= S_RUN;
            busy    <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sum_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sum_serial_ctrl
// Purpose  : Self-checking bench for sum_serial_ctrl with WIDTH=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sum_serial_ctrl;

  localparam int WIDTH = 4;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  sum_serial_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                                 input logic ic);
    exp_t           e;
    logic [WIDTH:0] t;
    t      = {1'b0, ia} + {1'b0, ib} + {{WIDTH{1'b0}}, ic};
    e.sum  = t[WIDTH-1:0];
    e.cout = t[WIDTH];
    e.ovf  = (ia[WIDTH-1] == ib[WIDTH-1]) && (t[WIDTH-1] != ia[WIDTH-1]);
    return e;
  endfunction

  // Launches one operation and waits for done; lat = negedges from drive to done, -1 on timeout.
  task automatic run_op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib, input logic ic,
                        output int lat, output int nbusy);
    @(negedge clk);
    a = ia; b = ib; cin = ic; start = 1'b1;
    q.push_back(model(ia, ib, ic));
    @(negedge clk);
    start = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
    lat = 1; nbusy = 0;
    while (!done && lat < 20) begin
      if (busy) nbusy++;
      @(negedge clk);
      lat++;
    end
    if (!done) lat = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b want=0", done); end
    n_cmp++; if ({sum, cout, ovf} !== '0) begin
      n_fail++; $display("FAIL reset_outputs got sum=%h cout=%b ovf=%b want 0", sum, cout, ovf);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if ({busy, done} !== 2'b00) begin
      n_fail++; $display("FAIL idle_after_reset got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    logic [WIDTH-1:0] ta[3] = '{4'd3, 4'd15, 4'd7};
    logic [WIDTH-1:0] tb[3] = '{4'd5, 4'd1,  4'd7};
    logic             tc[3] = '{1'b0, 1'b0,  1'b1};
    exp_t e;
    int   lat, nb;
    for (int i = 0; i < 3; i++) begin
      run_op(ta[i], tb[i], tc[i], lat, nb);
      n_cmp++; if (lat !== WIDTH + 1) begin
        n_fail++; $display("FAIL basic%0d_latency got=%0d want=%0d", i, lat, WIDTH + 1);
      end
      n_cmp++; if (nb !== WIDTH) begin
        n_fail++; $display("FAIL basic%0d_busy_cycles got=%0d want=%0d", i, nb, WIDTH);
      end
      e = (q.size() > 0) ? q.pop_front() : '0;
      n_cmp++; if ({sum, cout, ovf} !== {e.sum, e.cout, e.ovf}) begin
        n_fail++; $display("FAIL basic%0d_result got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                           i, sum, cout, ovf, e.sum, e.cout, e.ovf);
      end
      @(negedge clk);
      n_cmp++; if (done !== 1'b0) begin
        n_fail++; $display("FAIL basic%0d_done_width got=%b want=0", i, done);
      end
      n_cmp++; if (sum !== e.sum) begin
        n_fail++; $display("FAIL basic%0d_hold got sum=%h want=%h", i, sum, e.sum);
      end
    end
  endtask

  task automatic test_exhaustive();
    exp_t e;
    int   lat, nb;
    int   bad = 0;
    for (int i = 0; i < 512; i++) begin
      run_op(WIDTH'(i[3:0]), WIDTH'(i[7:4]), i[8], lat, nb);
      e = (q.size() > 0) ? q.pop_front() : '0;
      n_cmp++; if ({cout, sum} !== {e.cout, e.sum} || ovf !== e.ovf) begin
        n_fail++; bad++;
        if (bad < 10)
          $display("FAIL exh a=%0d b=%0d cin=%0d got cout/sum=%0d ovf=%b want %0d ovf=%b",
                   i[3:0], i[7:4], i[8], {cout, sum}, ovf, {e.cout, e.sum}, e.ovf);
      end
      n_cmp++; if (lat !== WIDTH + 1) begin
        n_fail++; bad++;
        if (bad < 10) $display("FAIL exh_latency idx=%0d got=%0d want=%0d", i, lat, WIDTH + 1);
      end
    end
  endtask

  task automatic test_ignore_start();
    exp_t e;
    int   t, dones;
    @(negedge clk);
    a = 4'd9; b = 4'd4; cin = 1'b0; start = 1'b1;
    q.push_back(model(4'd9, 4'd4, 1'b0));
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1; a = 4'd2; b = 4'd2; cin = 1'b1;
    @(negedge clk); start = 1'b0;
    t = 3;
    while (!done && t < 20) begin @(negedge clk); t++; end
    n_cmp++; if (t !== WIDTH + 1) begin
      n_fail++; $display("FAIL ignore_latency got=%0d want=%0d", t, WIDTH + 1);
    end
    e = (q.size() > 0) ? q.pop_front() : '0;
    n_cmp++; if ({sum, cout, ovf} !== {e.sum, e.cout, e.ovf}) begin
      n_fail++; $display("FAIL ignore_result got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                         sum, cout, ovf, e.sum, e.cout, e.ovf);
    end
    dones = 0;
    repeat (10) begin @(negedge clk); if (done) dones++; end
    n_cmp++; if (dones !== 0) begin
      n_fail++; $display("FAIL ignore_extra_done got=%0d want=0", dones);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   d1 = -1, d2 = -1, extra = 0;
    logic b6 = 1'b0;
    @(negedge clk);
    a = 4'd6; b = 4'd5; cin = 1'b0; start = 1'b1;
    q.push_back(model(4'd6, 4'd5, 1'b0));
    for (int t = 1; t <= 20; t++) begin
      @(negedge clk);
      if (t == 1) begin
        a = 4'd12; b = 4'd9; cin = 1'b1;
        q.push_back(model(4'd12, 4'd9, 1'b1));
      end
      if (t == WIDTH + 2) b6 = busy;
      if (done) begin
        e = (q.size() > 0) ? q.pop_front() : '0;
        n_cmp++; if ({sum, cout, ovf} !== {e.sum, e.cout, e.ovf}) begin
          n_fail++; $display("FAIL b2b_result t=%0d got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                             t, sum, cout, ovf, e.sum, e.cout, e.ovf);
        end
        if (d1 < 0) d1 = t;
        else if (d2 < 0) begin d2 = t; start = 1'b0; end
        else extra++;
      end
    end
    start = 1'b0;
    n_cmp++; if (d1 !== WIDTH + 1) begin
      n_fail++; $display("FAIL b2b_first_done got=%0d want=%0d", d1, WIDTH + 1);
    end
    n_cmp++; if (d2 - d1 !== WIDTH + 1) begin
      n_fail++; $display("FAIL b2b_spacing got=%0d want=%0d", d2 - d1, WIDTH + 1);
    end
    n_cmp++; if (b6 !== 1'b1) begin
      n_fail++; $display("FAIL b2b_no_idle_bubble got busy=%b want=1", b6);
    end
    n_cmp++; if (extra !== 0) begin
      n_fail++; $display("FAIL b2b_extra_done got=%0d want=0", extra);
    end
  endtask

  task automatic test_reset_mid_run();
    exp_t e;
    int   lat, nb, dones;
    @(negedge clk);
    a = 4'd3; b = 4'd3; cin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({busy, done, sum, cout, ovf} !== '0) begin
      n_fail++; $display("FAIL midrst_clear got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
                         busy, done, sum, cout, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (8) begin @(negedge clk); if (done || busy) dones++; end
    n_cmp++; if (dones !== 0) begin
      n_fail++; $display("FAIL midrst_stays_idle got=%0d active cycles want=0", dones);
    end
    run_op(4'd10, 4'd3, 1'b1, lat, nb);
    e = (q.size() > 0) ? q.pop_front() : '0;
    n_cmp++; if ({sum, cout, ovf} !== {e.sum, e.cout, e.ovf}) begin
      n_fail++; $display("FAIL midrst_next_result got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                         sum, cout, ovf, e.sum, e.cout, e.ovf);
    end
    n_cmp++; if (lat !== WIDTH + 1) begin
      n_fail++; $display("FAIL midrst_next_latency got=%0d want=%0d", lat, WIDTH + 1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_exhaustive();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    n_cmp++; if (q.size() !== 0) begin
      n_fail++; $display("FAIL scoreboard_leftover got=%0d want=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500us;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
